// File: rtl/fila_pedidos_cafe.sv
// Order queue and start sequencer in front of the coffee-machine FSM.
// Buffers 2-bit orders, fires a one-cycle start when the machine is idle and follows each brew.
module fila_pedidos_cafe #(
    parameter int PROFUNDIDADE = 4,
    parameter int TIMEOUT      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pedido,
    input  logic [1:0]                    tipo_pedido,
    input  logic [3:0]                    state,
    output logic                          start,
    output logic [1:0]                    tipo_atual,
    output logic                          ocupado,
    output logic [$clog2(PROFUNDIDADE):0] fila_cont,
    output logic                          cheia,
    output logic                          vazia,
    output logic [7:0]                    servidos,
    output logic [7:0]                    descartados,
    output logic                          erro_timeout
);

    localparam int PW = $clog2(PROFUNDIDADE);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;

    localparam logic [3:0]    M_IDLE     = 4'd1;
    localparam logic [3:0]    M_LIGAR    = 4'd2;
    localparam logic [3:0]    M_EXTRACAO = 4'd9;
    localparam logic [CW-1:0] CHEIO      = CW'(PROFUNDIDADE);
    // Last waiting cycle: the timer would reach TIMEOUT-1 on this edge.
    localparam logic [TW-1:0] T_ULTIMO   = TW'(TIMEOUT - 2);

    typedef enum logic [1:0] {
        ESPERA,
        DISPARO,
        AGUARDA_INICIO,
        EM_PREPARO
    } estado_t;

    estado_t       estado_q, estado_d;
    logic [1:0]    mem_q [PROFUNDIDADE];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cont_q, cont_d;
    logic          start_q, start_d;
    logic          ocupado_q, ocupado_d;
    logic [1:0]    tipo_q, tipo_d;
    logic [7:0]    serv_q, serv_d;
    logic [7:0]    desc_q, desc_d;
    logic          erro_q, erro_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          viu_q, viu_d;
    logic          push, pop;

    assign vazia        = (cont_q == '0);
    assign cheia        = (cont_q == CHEIO);
    assign fila_cont    = cont_q;
    assign start        = start_q;
    assign ocupado      = ocupado_q;
    assign tipo_atual   = tipo_q;
    assign servidos     = serv_q;
    assign descartados  = desc_q;
    assign erro_timeout = erro_q;

    always_comb begin
        estado_d  = estado_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        cont_d    = cont_q;
        start_d   = 1'b0;
        ocupado_d = ocupado_q;
        tipo_d    = tipo_q;
        serv_d    = serv_q;
        desc_d    = desc_q;
        erro_d    = erro_q;
        timer_d   = timer_q;
        viu_d     = viu_q;

        pop  = (estado_q == ESPERA) && !vazia && (state == M_IDLE);
        // A full queue still accepts an order when the head leaves on the same edge.
        push = pedido && (!cheia || pop);

        if (push) wr_d = wr_q + PW'(1);
        if (pop)  rd_d = rd_q + PW'(1);
        if (pedido && !push) desc_d = desc_q + 8'd1;

        case ({push, pop})
            2'b10:   cont_d = cont_q + CW'(1);
            2'b01:   cont_d = cont_q - CW'(1);
            default: cont_d = cont_q;
        endcase

        case (estado_q)
            ESPERA: begin
                if (pop) begin
                    tipo_d    = mem_q[rd_q];
                    start_d   = 1'b1;
                    ocupado_d = 1'b1;
                    estado_d  = DISPARO;
                end
            end
            DISPARO: begin
                timer_d  = '0;
                estado_d = AGUARDA_INICIO;
            end
            AGUARDA_INICIO: begin
                if (state == M_LIGAR) begin
                    estado_d = EM_PREPARO;
                end else if (timer_q == T_ULTIMO) begin
                    erro_d    = 1'b1;
                    ocupado_d = 1'b0;
                    estado_d  = ESPERA;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            EM_PREPARO: begin
                if (state == M_EXTRACAO) begin
                    viu_d = 1'b1;
                end else if (state == M_IDLE) begin
                    // Idle without extraction means the machine reset itself: no credit.
                    if (viu_q) serv_d = serv_q + 8'd1;
                    ocupado_d = 1'b0;
                    viu_d     = 1'b0;
                    estado_d  = ESPERA;
                end
            end
            default: estado_d = ESPERA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q  <= ESPERA;
            wr_q      <= '0;
            rd_q      <= '0;
            cont_q    <= '0;
            start_q   <= 1'b0;
            ocupado_q <= 1'b0;
            tipo_q    <= 2'd0;
            serv_q    <= 8'd0;
            desc_q    <= 8'd0;
            erro_q    <= 1'b0;
            timer_q   <= '0;
            viu_q     <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            cont_q    <= cont_d;
            start_q   <= start_d;
            ocupado_q <= ocupado_d;
            tipo_q    <= tipo_d;
            serv_q    <= serv_d;
            desc_q    <= desc_d;
            erro_q    <= erro_d;
            timer_q   <= timer_d;
            viu_q     <= viu_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= tipo_pedido;
    end

endmodule

// File: tb/tb_fila_pedidos_cafe.sv
// Bench for fila_pedidos_cafe: a scripted coffee-machine model plus a queue-based
// reference of the sequencer, compared every cycle and at scenario checkpoints.
module tb_fila_pedidos_cafe;

    localparam int PROF = 4;
    localparam int TMO  = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       pedido;
    logic [1:0] tipo_pedido;
    logic [3:0] state;
    logic       start;
    logic [1:0] tipo_atual;
    logic       ocupado;
    logic [2:0] fila_cont;
    logic       cheia;
    logic       vazia;
    logic [7:0] servidos;
    logic [7:0] descartados;
    logic       erro_timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fila_pedidos_cafe #(.PROFUNDIDADE(PROF), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .pedido(pedido), .tipo_pedido(tipo_pedido), .state(state),
        .start(start), .tipo_atual(tipo_atual), .ocupado(ocupado), .fila_cont(fila_cont),
        .cheia(cheia), .vazia(vazia), .servidos(servidos), .descartados(descartados),
        .erro_timeout(erro_timeout)
    );

    // Reference: queued orders, whether a brew is in flight, and how old it is.
    logic [1:0] m_q[$];
    bit         m_busy, m_start, m_ack, m_ext, m_erro;
    int         m_age;
    logic [1:0] m_tipo;
    logic [7:0] m_serv, m_desc;

    // Machine model: scripted state sequence played after each start pulse.
    logic [3:0] mq[$];
    logic [3:0] mach_idle = 4'd1;
    int         mach_kind = 0;
    bit         mach_rand = 1'b0;

    int         cyc, n_starts, first_start, erro_cyc;
    logic [1:0] obs_tipos[$];

    task automatic model_reset();
        m_q.delete();
        m_busy = 0; m_start = 0; m_ack = 0; m_ext = 0; m_erro = 0;
        m_age = 0; m_tipo = 2'd0; m_serv = 8'd0; m_desc = 8'd0;
    endtask

    task automatic clear_obs();
        cyc = 0; n_starts = 0; first_start = -1; erro_cyc = -1;
        obs_tipos.delete();
    endtask

    task automatic model_step(input bit ped, input logic [1:0] tp, input logic [3:0] st);
        bit disp;
        disp = !m_busy && (m_q.size() > 0) && (st == 4'd1);
        if (disp) begin
            m_tipo = m_q.pop_front();
            m_busy = 1; m_age = 0; m_ack = 0; m_ext = 0;
        end else if (m_busy) begin
            if (!m_start) begin
                if (!m_ack) begin
                    if (st == 4'd2) m_ack = 1;
                    else if (m_age == TMO - 1) begin m_erro = 1; m_busy = 0; end
                end else begin
                    if (st == 4'd9) m_ext = 1;
                    else if (st == 4'd1) begin
                        if (m_ext) m_serv = m_serv + 8'd1;
                        m_busy = 0;
                    end
                end
            end
            m_age++;
        end
        if (ped) begin
            if (m_q.size() < PROF) m_q.push_back(tp);
            else m_desc = m_desc + 8'd1;
        end
        m_start = disp;
    endtask

    task automatic add_normal();
        logic [3:0] seq [7] = '{4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
        for (int i = 0; i < 7; i++) begin
            int reps;
            reps = $urandom_range(1, 2);
            for (int r = 0; r < reps; r++) mq.push_back(seq[i]);
        end
    endtask

    task automatic mach_fill();
        int k;
        k = mach_rand ? int'($urandom_range(0, 3)) : mach_kind;
        case (k)
            0: add_normal();
            1: begin mq.push_back(4'd2); mq.push_back(4'd3); mq.push_back(4'd5); mq.push_back(4'd5); end
            2: ;
            default: begin
                int d;
                d = $urandom_range(0, TMO);
                for (int i = 0; i < d; i++) mq.push_back(4'd1);
                add_normal();
            end
        endcase
    endtask

    task automatic ciclo(input bit ped, input logic [1:0] tp);
        bit pstart;
        pedido = ped;
        tipo_pedido = tp;
        @(negedge clk);
        cyc++;
        if (start === 1'b1) begin
            n_starts++;
            if (first_start < 0) first_start = cyc;
            obs_tipos.push_back(tipo_atual);
        end
        if (erro_timeout === 1'b1 && erro_cyc < 0) erro_cyc = cyc;
        checks++; if (fila_cont !== 3'(m_q.size())) begin errors++; $display("FAIL fila_cont cyc %0d: got %0d expected %0d", cyc, fila_cont, m_q.size()); end
        checks++; if (start !== m_start) begin errors++; $display("FAIL start cyc %0d: got %b expected %b", cyc, start, m_start); end
        checks++; if (ocupado !== m_busy) begin errors++; $display("FAIL ocupado cyc %0d: got %b expected %b", cyc, ocupado, m_busy); end
        checks++; if (tipo_atual !== m_tipo) begin errors++; $display("FAIL tipo_atual cyc %0d: got %0d expected %0d", cyc, tipo_atual, m_tipo); end
        checks++; if (servidos !== m_serv) begin errors++; $display("FAIL servidos cyc %0d: got %0d expected %0d", cyc, servidos, m_serv); end
        checks++; if (descartados !== m_desc) begin errors++; $display("FAIL descartados cyc %0d: got %0d expected %0d", cyc, descartados, m_desc); end
        checks++; if (erro_timeout !== m_erro) begin errors++; $display("FAIL erro_timeout cyc %0d: got %b expected %b", cyc, erro_timeout, m_erro); end
        checks++; if (cheia !== (m_q.size() == PROF)) begin errors++; $display("FAIL cheia cyc %0d: got %b expected %b", cyc, cheia, m_q.size() == PROF); end
        checks++; if (vazia !== (m_q.size() == 0)) begin errors++; $display("FAIL vazia cyc %0d: got %b expected %b", cyc, vazia, m_q.size() == 0); end
        pstart = m_start;
        model_step(ped, tp, state);
        @(posedge clk);
        #1;
        if (pstart && mq.size() == 0) mach_fill();
        if (mq.size() > 0) state = mq.pop_front();
        else state = mach_idle;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pedido = 1'b0;
        tipo_pedido = 2'd0;
        mq.delete();
        state = mach_idle;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        clear_obs();
    endtask

    task automatic test_reset();
        mach_idle = 4'd1; mach_rand = 0; mach_kind = 0;
        do_reset();
        checks++;
        if ({fila_cont, vazia, cheia, start, ocupado, erro_timeout} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_flags: got %b expected %b", {fila_cont, vazia, cheia, start, ocupado, erro_timeout}, 8'b000_1_0_0_0_0);
        end
        checks++;
        if ({tipo_atual, servidos, descartados} !== 18'd0) begin
            errors++;
            $display("FAIL reset_counters: got %h expected 0", {tipo_atual, servidos, descartados});
        end
        repeat (3) ciclo(1'b0, 2'd0);
    endtask

    task automatic test_single();
        mach_idle = 4'd1; mach_rand = 0; mach_kind = 0;
        do_reset();
        ciclo(1'b1, 2'd2);
        repeat (30) ciclo(1'b0, 2'd0);
        checks++; if (n_starts !== 1) begin errors++; $display("FAIL single_starts: got %0d expected 1", n_starts); end
        checks++; if (first_start !== 3) begin errors++; $display("FAIL single_start_cycle: got %0d expected 3", first_start); end
        checks++; if (tipo_atual !== 2'd2) begin errors++; $display("FAIL single_tipo: got %0d expected 2", tipo_atual); end
        checks++; if (servidos !== 8'd1) begin errors++; $display("FAIL single_servidos: got %0d expected 1", servidos); end
        checks++; if (vazia !== 1'b1) begin errors++; $display("FAIL single_vazia: got %b expected 1", vazia); end
    endtask

    task automatic test_overflow();
        logic [1:0] tipos [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        mach_idle = 4'd3; mach_rand = 0; mach_kind = 0;
        do_reset();
        for (int i = 0; i < 6; i++) ciclo(1'b1, tipos[i]);
        ciclo(1'b0, 2'd0);
        checks++; if (fila_cont !== 3'd4) begin errors++; $display("FAIL ovf_fila_cont: got %0d expected 4", fila_cont); end
        checks++; if (cheia !== 1'b1) begin errors++; $display("FAIL ovf_cheia: got %b expected 1", cheia); end
        checks++; if (descartados !== 8'd2) begin errors++; $display("FAIL ovf_descartados: got %0d expected 2", descartados); end
        mach_idle = 4'd1;
        state = 4'd1;
        repeat (100) ciclo(1'b0, 2'd0);
        checks++; if (obs_tipos.size() !== 4) begin errors++; $display("FAIL ovf_n_served: got %0d expected 4", obs_tipos.size()); end
        for (int i = 0; i < 4 && i < obs_tipos.size(); i++) begin
            checks++;
            if (obs_tipos[i] !== tipos[i]) begin errors++; $display("FAIL ovf_order[%0d]: got %0d expected %0d", i, obs_tipos[i], tipos[i]); end
        end
        checks++; if (servidos !== 8'd4) begin errors++; $display("FAIL ovf_servidos: got %0d expected 4", servidos); end
    endtask

    task automatic test_push_pop_full();
        mach_idle = 4'd3; mach_rand = 0; mach_kind = 0;
        do_reset();
        for (int i = 0; i < 4; i++) ciclo(1'b1, 2'(i));
        ciclo(1'b0, 2'd0);
        checks++; if (cheia !== 1'b1) begin errors++; $display("FAIL pp_cheia_before: got %b expected 1", cheia); end
        mach_idle = 4'd1;
        state = 4'd1;
        ciclo(1'b1, 2'd3);
        checks++; if (fila_cont !== 3'd4) begin errors++; $display("FAIL pp_fila_cont: got %0d expected 4", fila_cont); end
        checks++; if (descartados !== 8'd0) begin errors++; $display("FAIL pp_descartados: got %0d expected 0", descartados); end
        repeat (110) ciclo(1'b0, 2'd0);
        checks++; if (servidos !== 8'd5) begin errors++; $display("FAIL pp_servidos: got %0d expected 5", servidos); end
    endtask

    task automatic test_timeout();
        mach_idle = 4'd1; mach_rand = 0; mach_kind = 2;
        do_reset();
        ciclo(1'b1, 2'd1);
        ciclo(1'b1, 2'd2);
        repeat (30) ciclo(1'b0, 2'd0);
        checks++; if (erro_cyc - first_start !== TMO) begin errors++; $display("FAIL to_latency: got %0d expected %0d", erro_cyc - first_start, TMO); end
        checks++; if (n_starts !== 2) begin errors++; $display("FAIL to_next_dispatched: got %0d expected 2", n_starts); end
        checks++; if (servidos !== 8'd0) begin errors++; $display("FAIL to_servidos: got %0d expected 0", servidos); end
        checks++; if (ocupado !== 1'b0) begin errors++; $display("FAIL to_ocupado: got %b expected 0", ocupado); end
        checks++; if (erro_timeout !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b expected 1", erro_timeout); end
    endtask

    task automatic test_abort();
        mach_idle = 4'd1; mach_rand = 0; mach_kind = 1;
        do_reset();
        ciclo(1'b1, 2'd3);
        repeat (20) ciclo(1'b0, 2'd0);
        checks++; if (servidos !== 8'd0) begin errors++; $display("FAIL abort_servidos: got %0d expected 0", servidos); end
        checks++; if (ocupado !== 1'b0) begin errors++; $display("FAIL abort_ocupado: got %b expected 0", ocupado); end
        checks++; if (erro_timeout !== 1'b0) begin errors++; $display("FAIL abort_erro: got %b expected 0", erro_timeout); end
        mach_kind = 0;
        ciclo(1'b1, 2'd0);
        repeat (25) ciclo(1'b0, 2'd0);
        checks++; if (n_starts !== 2) begin errors++; $display("FAIL abort_redispatch: got %0d expected 2", n_starts); end
        checks++; if (servidos !== 8'd1) begin errors++; $display("FAIL abort_then_serve: got %0d expected 1", servidos); end
    endtask

    task automatic test_reset_mid();
        mach_idle = 4'd1; mach_rand = 0; mach_kind = 2;
        do_reset();
        ciclo(1'b1, 2'd1);
        repeat (12) ciclo(1'b0, 2'd0);
        mach_kind = 0;
        ciclo(1'b1, 2'd2);
        repeat (25) ciclo(1'b0, 2'd0);
        for (int i = 0; i < 4; i++) ciclo(1'b1, 2'(i));
        repeat (2) ciclo(1'b0, 2'd0);
        checks++;
        if ({fila_cont, ocupado, servidos, erro_timeout} !== {3'd3, 1'b1, 8'd1, 1'b1}) begin
            errors++;
            $display("FAIL mid_before_reset: got %h expected %h", {fila_cont, ocupado, servidos, erro_timeout}, {3'd3, 1'b1, 8'd1, 1'b1});
        end
        do_reset();
        checks++;
        if ({fila_cont, start, ocupado, servidos, erro_timeout} !== 14'd0) begin
            errors++;
            $display("FAIL mid_after_reset: got %h expected 0", {fila_cont, start, ocupado, servidos, erro_timeout});
        end
        repeat (10) ciclo(1'b0, 2'd0);
    endtask

    task automatic test_random();
        mach_idle = 4'd1; mach_rand = 1; mach_kind = 0;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            bit         p;
            logic [1:0] t;
            p = ($urandom_range(0, 2) == 0);
            t = 2'($urandom_range(0, 3));
            ciclo(p, t);
        end
        mach_rand = 0;
        repeat (200) ciclo(1'b0, 2'd0);
        checks++; if (servidos !== m_serv) begin errors++; $display("FAIL rnd_servidos: got %0d expected %0d", servidos, m_serv); end
        checks++; if (fila_cont !== 3'd0) begin errors++; $display("FAIL rnd_drained: got %0d expected 0", fila_cont); end
    endtask

    initial begin
        rst = 1'b1;
        pedido = 1'b0;
        tipo_pedido = 2'd0;
        state = 4'd1;
        model_reset();
        clear_obs();
        test_reset();
        test_single();
        test_overflow();
        test_push_pop_full();
        test_timeout();
        test_abort();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fila_pedidos_cafe.md
Name: fila_pedidos_cafe

Overview:
- Order queue and start sequencer sitting directly upstream of the coffee-machine FSM.
- Buffers user coffee orders (2-bit type) in a small FIFO.
- Issues a one-cycle `start` pulse to the machine only when the machine reports IDLE.
- Tracks each brew via the machine's 4-bit `state` output and counts served and dropped orders.

Parameters:
- PROFUNDIDADE, 4, FIFO depth in orders; power of two, ≥2.
- TIMEOUT, 8, cycles to wait for machine state LIGAR_MAQUINA after `start` before flagging an error.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-high.
- pedido  input  1  push strobe; one order per cycle high.
- tipo_pedido  input  2  order type, sampled with `pedido`.
- state  input  4  machine state: 1=IDLE, 2=LIGAR_MAQUINA, 9=REALIZAR_EXTRACAO.
- start  output  1  registered one-cycle start pulse to the machine.
- tipo_atual  output  2  type of the order currently being brewed.
- ocupado  output  1  high from `start` until brew completion or timeout.
- fila_cont  output  3  orders queued, 0..PROFUNDIDADE; width clog2(PROFUNDIDADE)+1.
- cheia  output  1  fila_cont == PROFUNDIDADE.
- vazia  output  1  fila_cont == 0.
- servidos  output  8  completed brews, wraps 255→0.
- descartados  output  8  orders dropped because the queue was full, wraps.
- erro_timeout  output  1  sticky; set on start timeout.

Behaviour:
- Reset: rst high at a clk edge clears everything.
  - FIFO pointers and fila_cont → 0; vazia=1, cheia=0.
  - start=0, ocupado=0, tipo_atual=0, servidos=0, descartados=0, erro_timeout=0.
  - FSM → ESPERA.
  - Reset mid-brew abandons the order silently; no count changes.
- FIFO push:
  - pedido=1 with (!cheia or pop in the same cycle) writes tipo_pedido at the write pointer.
  - pedido=1 while cheia and no same-cycle pop → order dropped, descartados += 1.
- FIFO pop: occurs only on the ESPERA→DISPARO transition.
- Simultaneous push and pop: fila_cont is unchanged.
- Pointers wrap modulo PROFUNDIDADE.
- FSM states:
  - ESPERA: if !vazia and state==1 → DISPARO. Same cycle: pop the head into tipo_atual, start<=1, ocupado<=1.
  - DISPARO: start is high this cycle only. start<=0, timer<=0, → AGUARDA_INICIO.
  - AGUARDA_INICIO:
    - If state==2 → EM_PREPARO.
    - Else timer += 1. When timer reaches TIMEOUT-1 without state==2: erro_timeout<=1, ocupado<=0, → ESPERA. The order is lost and not counted.
  - EM_PREPARO:
    - Sets an internal flag `viu_extracao` when state==9.
    - When state==1 and viu_extracao: servidos += 1, ocupado<=0, clear flag, → ESPERA.
    - state==1 without prior extraction (machine reset) → ESPERA. ocupado<=0, no count.
- Latency:
  - With the machine idle and the queue empty, `pedido` at cycle N is queued at edge N.
  - ESPERA sees !vazia in cycle N+1; `start` is high in cycle N+2.
  - The machine shows state 2 in cycle N+3.
- No back-to-back start: at least one full ESPERA cycle observes state==1 after each brew.
- erro_timeout clears only on rst.
- tipo_atual holds its value until the next pop.

Test Plan:
- Single order: rst, then pedido=1 with tipo=2 for one cycle; machine model runs 1→2→3→5..9→1.
  - Expect exactly one start pulse two cycles after pedido, tipo_atual=2, servidos=1, vazia=1 at the end.
- Overflow: with the machine held non-IDLE, push 6 orders with types 0,1,2,3,0,1.
  - Expect fila_cont=4, cheia=1, descartados=2.
  - Releasing the machine serves types 0,1,2,3 in order; servidos=4.
- Push and pop together when full: at cheia, pedido coincides with the ESPERA→DISPARO pop.
  - Expect fila_cont stays 4, descartados unchanged.
- Timeout: machine model ignores start and stays at state=1.
  - Expect erro_timeout=1 exactly TIMEOUT cycles after DISPARO, ocupado=0, servidos=0.
  - Next queued order is still dispatched.
- Brew abort: machine forced to state 1 while in state 5 (before extraction).
  - Expect servidos unchanged, ocupado=0, FSM returns to ESPERA.
- Reset mid-operation: assert rst while in EM_PREPARO with 3 orders queued.
  - Expect next cycle fila_cont=0, start=0, servidos=0, erro_timeout=0.
